sa_weight_fetch_ctrl: RTL

//  Sequencer upstream of the SA weight address decoder. On start, steps a 4-bit

---
 rtl/sa_weight_fetch_ctrl_if.sv | 30 +++
 rtl/sa_weight_fetch_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/sa_weight_fetch_ctrl_if.sv
// Bus bundle between the weight-fetch sequencer and its environment (buffer + consumer).
// mem_gnt exists only when SA_WFETCH_STALL_EN is defined.
interface sa_weight_fetch_ctrl_if #(
    parameter int unsigned DW = 8
);
    logic          start;
    logic [3:0]    cnt;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
`ifdef SA_WFETCH_STALL_EN
    logic          mem_gnt;
`endif
    logic          w_valid;
    logic [3:0]    w_idx;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          done;

`ifdef SA_WFETCH_STALL_EN
    modport master (input start, mem_rdata, mem_gnt,
                    output cnt, mem_rd_en, w_valid, w_idx, w_data, busy, done);
    modport slave  (output start, mem_rdata, mem_gnt,
                    input cnt, mem_rd_en, w_valid, w_idx, w_data, busy, done);
`else
    modport master (input start, mem_rdata,
                    output cnt, mem_rd_en, w_valid, w_idx, w_data, busy, done);
    modport slave  (output start, mem_rdata,
                    input cnt, mem_rd_en, w_valid, w_idx, w_data, busy, done);
`endif
endinterface

// File: rtl/sa_weight_fetch_ctrl.sv
// Weight-fetch sequencer: steps cnt 0..NUM_W-1, issues buffer reads, registers returned
// weights tagged with their step index. Optional read stall: define SA_WFETCH_STALL_EN.
module sa_weight_fetch_ctrl #(
    parameter int unsigned DW     = 8,
    parameter int unsigned NUM_W  = 9,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    sa_weight_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NUM_W - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_valid_q, w_valid_d;
    logic [3:0]        w_idx_q, w_idx_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [3:0]        pi_q [RD_LAT];
    logic [3:0]        pi_d [RD_LAT];
    logic              grant;
    logic              issue;

`ifdef SA_WFETCH_STALL_EN
    assign grant = bus.mem_gnt;
`else
    assign grant = 1'b1;
`endif
    assign issue = mem_rd_en_q & grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (issue && cnt_q == LAST) state_d = DRAIN;
            DRAIN:   if (w_valid_q && w_idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        cnt_d = '0;
        if (state_d == FETCH) cnt_d = issue ? cnt_q + 4'd1 : cnt_q;
        mem_rd_en_d = (state_d == FETCH);
        busy_d      = (state_d == FETCH) || (state_d == DRAIN);
        done_d      = (state_d == DONE);

        pv_d    = pv_q << 1;
        pv_d[0] = issue;
        pi_d[0] = cnt_q;
        for (int unsigned i = 1; i < RD_LAT; i++) pi_d[i] = pi_q[i-1];

        w_valid_d = pv_q[RD_LAT-1];
        w_idx_d   = w_idx_q;
        w_data_d  = w_data_q;
        if (pv_q[RD_LAT-1]) begin
            w_idx_d  = pi_q[RD_LAT-1];
            w_data_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_valid_q   <= 1'b0;
            w_idx_q     <= '0;
            w_data_q    <= '0;
            pv_q        <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) pi_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_valid_q   <= w_valid_d;
            w_idx_q     <= w_idx_d;
            w_data_q    <= w_data_d;
            pv_q        <= pv_d;
            pi_q        <= pi_d;
        end
    end

    assign bus.cnt       = cnt_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_idx     = w_idx_q;
    assign bus.w_data    = w_data_q;
endmodule
